// File: rtl/weight_route_ctrl_if.sv
// Descriptor, source-monitor and router-control signals of the weight route controller.
// master drives descriptors and monitor copies; slave is the controller itself.
interface weight_route_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             clr;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_in_sel;
  logic             cfg_out_sel;
  logic [LEN_W-1:0] cfg_addr_len;
  logic [LEN_W-1:0] cfg_data_len;
  logic             mon_addr_valid;
  logic             mon_addr_ready;
  logic             mon_data_valid;
  logic             mon_data_ready;
  logic             data_in_sel;
  logic             data_out_sel;
  logic             addr_en;
  logic             data_en;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] addr_cnt;
  logic [LEN_W-1:0] data_cnt;

  modport master (
    output clr,
    output cfg_valid,
    input  cfg_ready,
    output cfg_in_sel,
    output cfg_out_sel,
    output cfg_addr_len,
    output cfg_data_len,
    output mon_addr_valid,
    output mon_addr_ready,
    output mon_data_valid,
    output mon_data_ready,
    input  data_in_sel,
    input  data_out_sel,
    input  addr_en,
    input  data_en,
    input  busy,
    input  done,
    input  addr_cnt,
    input  data_cnt
  );

  modport slave (
    input  clr,
    input  cfg_valid,
    output cfg_ready,
    input  cfg_in_sel,
    input  cfg_out_sel,
    input  cfg_addr_len,
    input  cfg_data_len,
    input  mon_addr_valid,
    input  mon_addr_ready,
    input  mon_data_valid,
    input  mon_data_ready,
    output data_in_sel,
    output data_out_sel,
    output addr_en,
    output data_en,
    output busy,
    output done,
    output addr_cnt,
    output data_cnt
  );
endinterface

// File: rtl/weight_route_ctrl.sv
// Sequences one weight transfer through the router: address beats, then data beats,
// then a one-cycle done pulse, counting beats seen on the selected source port.
module weight_route_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  weight_route_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  localparam logic [LEN_W-1:0] CntOne = LEN_W'(1);

  state_e           state_q, state_d;
  logic             in_sel_q, in_sel_d;
  logic             out_sel_q, out_sel_d;
  logic [LEN_W-1:0] addr_len_q, addr_len_d;
  logic [LEN_W-1:0] data_len_q, data_len_d;
  logic [LEN_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [LEN_W-1:0] data_cnt_q, data_cnt_d;

  logic cfg_ready;
  logic accept;
  logic addr_beat, data_beat;
  logic addr_last, data_last;

  // Beats only qualify inside their own phase; stray handshakes elsewhere are dropped.
  assign accept    = bus.cfg_valid & cfg_ready;
  assign addr_beat = (state_q == StAddr) & bus.mon_addr_valid & bus.mon_addr_ready;
  assign data_beat = (state_q == StData) & bus.mon_data_valid & bus.mon_data_ready;
  assign addr_last = (addr_cnt_q == addr_len_q - CntOne);
  assign data_last = (data_cnt_q == data_len_q - CntOne);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_sel_q   <= 1'b0;
      out_sel_q  <= 1'b0;
      addr_len_q <= '0;
      data_len_q <= '0;
      addr_cnt_q <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_sel_q   <= in_sel_d;
      out_sel_q  <= out_sel_d;
      addr_len_q <= addr_len_d;
      data_len_q <= data_len_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_sel_d   = in_sel_q;
    out_sel_d  = out_sel_q;
    addr_len_d = addr_len_q;
    data_len_d = data_len_q;
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;
    if (bus.clr) begin
      state_d    = StIdle;
      addr_cnt_d = '0;
      data_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            in_sel_d   = bus.cfg_in_sel;
            out_sel_d  = bus.cfg_out_sel;
            addr_len_d = bus.cfg_addr_len;
            data_len_d = bus.cfg_data_len;
            addr_cnt_d = '0;
            data_cnt_d = '0;
            if (bus.cfg_addr_len != '0) begin
              state_d = StAddr;
            end else if (bus.cfg_data_len != '0) begin
              state_d = StData;
            end else begin
              state_d = StDone;
            end
          end
        end
        StAddr: begin
          if (addr_beat) begin
            addr_cnt_d = addr_cnt_q + CntOne;
            if (addr_last) begin
              state_d = (data_len_q != '0) ? StData : StDone;
            end
          end
        end
        StData: begin
          if (data_beat) begin
            data_cnt_d = data_cnt_q + CntOne;
            if (data_last) begin
              state_d = StDone;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cfg_ready        = 1'b0;
    bus.data_in_sel  = 1'b0;
    bus.data_out_sel = 1'b0;
    bus.addr_en      = 1'b0;
    bus.data_en      = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    case (state_q)
      StIdle: cfg_ready = ~bus.clr;
      StAddr: begin
        bus.data_in_sel  = in_sel_q;
        bus.data_out_sel = out_sel_q;
        bus.addr_en      = 1'b1;
        bus.busy         = 1'b1;
      end
      StData: begin
        bus.data_in_sel  = in_sel_q;
        bus.data_out_sel = out_sel_q;
        bus.data_en      = 1'b1;
        bus.busy         = 1'b1;
      end
      StDone: begin
        bus.data_in_sel  = in_sel_q;
        bus.data_out_sel = out_sel_q;
        bus.busy         = 1'b1;
        // An abort landing on the completion cycle must not look like a finished transfer.
        bus.done         = ~bus.clr;
      end
      default: cfg_ready = 1'b0;
    endcase
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.addr_cnt  = addr_cnt_q;
  assign bus.data_cnt  = data_cnt_q;

endmodule

// File: tb/tb_weight_route_ctrl.sv
// Directed bench for weight_route_ctrl: descriptors push expected completions into a
// queue and a negedge monitor checks every done pulse plus per-cycle select/enable behaviour.
module tb_weight_route_ctrl;
  localparam int unsigned LW = 8;

  logic clk;
  logic rst_n;

  weight_route_ctrl_if #(.LEN_W(LW)) bus ();

  weight_route_ctrl #(.LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit in_sel;
    bit out_sel;
    int acnt;
    int dcnt;
    int acyc;
    int dcyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   a_cyc  = 0;
  int   d_cyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: tallies enable cycles per transfer and scores each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.busy) begin
        chk("idle_sel", int'({bus.data_in_sel, bus.data_out_sel}), 0);
        a_cyc = 0;
        d_cyc = 0;
      end else begin
        if (bus.addr_en) a_cyc++;
        if (bus.data_en) d_cyc++;
        chk("en_exclusive", int'(bus.addr_en & bus.data_en), 0);
        if (exp_q.size() != 0) begin
          chk("route_sel", int'({bus.data_in_sel, bus.data_out_sel}),
              int'({exp_q[0].in_sel, exp_q[0].out_sel}));
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            automatic exp_t e = exp_q.pop_front();
            chk("done_addr_cnt", int'(bus.addr_cnt), e.acnt);
            chk("done_data_cnt", int'(bus.data_cnt), e.dcnt);
            chk("addr_en_cycles", a_cyc, e.acyc);
            chk("data_en_cycles", d_cyc, e.dcyc);
          end
        end
      end
    end
  end

  // Offers one descriptor; returns just after the edge that ends the first busy cycle.
  task automatic send(input bit in_sel, input bit out_sel, input int al, input int dl,
                      input bit expect_done, input int acyc, input int dcyc);
    exp_t e;
    bus.cfg_in_sel   = in_sel;
    bus.cfg_out_sel  = out_sel;
    bus.cfg_addr_len = LW'(al);
    bus.cfg_data_len = LW'(dl);
    bus.cfg_valid    = 1'b1;
    if (expect_done) begin
      e.in_sel  = in_sel;
      e.out_sel = out_sel;
      e.acnt    = al;
      e.dcnt    = dl;
      e.acyc    = acyc;
      e.dcyc    = dcyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("cfg_ready_before_accept", int'(bus.cfg_ready), 1);
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", int'(bus.busy), 1);
    if (al != 0) chk("first_addr_en", int'(bus.addr_en), 1);
    else if (dl != 0) chk("first_data_en", int'(bus.data_en), 1);
    else chk("direct_done", int'(bus.done), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n              = 1'b1;
    bus.clr            = 1'b0;
    bus.cfg_valid      = 1'b0;
    bus.cfg_in_sel     = 1'b0;
    bus.cfg_out_sel    = 1'b0;
    bus.cfg_addr_len   = '0;
    bus.cfg_data_len   = '0;
    bus.mon_addr_valid = 1'b1;
    bus.mon_addr_ready = 1'b1;
    bus.mon_data_valid = 1'b1;
    bus.mon_data_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_en", int'({bus.addr_en, bus.data_en}), 0);
    chk("rst_cnts", int'({bus.addr_cnt, bus.data_cnt}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Address then data, multicast destination, sources always ready.
    send(1'b0, 1'b1, 3, 5, 1'b1, 3, 5);
    wait_drain(30);

    // No address phase.
    send(1'b0, 1'b0, 0, 2, 1'b1, 0, 2);
    wait_drain(20);

    // Empty descriptor goes straight to done.
    send(1'b1, 1'b1, 0, 0, 1'b1, 0, 0);
    wait_drain(10);

    // Address ready low on odd ADDR cycles; data handshakes active throughout ADDR.
    bus.mon_addr_ready = 1'b0;
    send(1'b1, 1'b0, 4, 2, 1'b1, 8, 2);
    for (int k = 2; k <= 8; k++) begin
      bus.mon_addr_ready = (k % 2 == 0);
      @(negedge clk);
      chk("alt_addr_cnt", int'(bus.addr_cnt), (k - 1) / 2);
      chk("alt_data_cnt_held", int'(bus.data_cnt), 0);
      @(posedge clk);
      #1;
    end
    bus.mon_addr_ready = 1'b1;
    wait_drain(20);

    // Abort after two data beats of five.
    send(1'b0, 1'b1, 0, 5, 1'b0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_clr_data_cnt", int'(bus.data_cnt), 2);
    bus.clr = 1'b1;
    @(negedge clk);
    chk("clr_still_busy", int'(bus.busy), 1);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    @(negedge clk);
    chk("clr_idle", int'(bus.busy), 0);
    chk("clr_cnts", int'({bus.addr_cnt, bus.data_cnt}), 0);
    chk("clr_ready", int'(bus.cfg_ready), 1);
    @(posedge clk);
    #1;
    bus.clr = 1'b1;
    #1;
    chk("clr_blocks_ready", int'(bus.cfg_ready), 0);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    send(1'b0, 1'b1, 1, 1, 1'b1, 1, 1);
    wait_drain(10);

    // Asynchronous reset in the middle of a data phase.
    send(1'b1, 1'b1, 0, 5, 1'b0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_ready", int'(bus.cfg_ready), 1);
    chk("arst_en", int'({bus.addr_en, bus.data_en}), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_sel", int'({bus.data_in_sel, bus.data_out_sel}), 0);
    chk("arst_cnts", int'({bus.addr_cnt, bus.data_cnt}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(1'b1, 1'b0, 2, 3, 1'b1, 2, 3);
    wait_drain(20);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_route_ctrl.md
WEIGHT_ROUTE_CTRL -- requirements
Module: weight_route_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, SHALL set the width of the beat-length fields and the beat counters.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 clr  input  1  SHALL be a synchronous abort that returns the block to IDLE.
REQ-005 cfg_valid  input  1  SHALL indicate that a transfer descriptor is offered.
REQ-006 cfg_ready  output  1  SHALL indicate that the descriptor can be accepted.
REQ-007 cfg_in_sel  input  1  SHALL give the router source for the transfer: 0 = GLB, 1 = HORIZ.
REQ-008 cfg_out_sel  input  1  SHALL give the router destination mode for the transfer: 0 = UNICAST, 1 = HOR_MULTICAST.
REQ-009 cfg_addr_len  input  LEN_W  SHALL give the number of address beats to transfer; 0 SHALL skip the address phase.
REQ-010 cfg_data_len  input  LEN_W  SHALL give the number of data beats to transfer; 0 SHALL skip the data phase.
REQ-011 mon_addr_valid, mon_addr_ready  input  1 each  SHALL be a copy of the address handshake at the selected router source port.
REQ-012 mon_data_valid, mon_data_ready  input  1 each  SHALL be a copy of the data handshake at the selected router source port.
REQ-013 data_in_sel, data_out_sel  output  1 each  SHALL drive the router mode-select controls.
REQ-014 addr_en, data_en  output  1 each  SHALL be the enables that permit the source to stream address beats and data beats respectively.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-016 done  output  1  SHALL be a single-cycle completion pulse.
REQ-017 addr_cnt, data_cnt  output  LEN_W each  SHALL report the number of beats accepted so far in the current transfer.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ADDR, DATA and DONE.
REQ-019 cfg_ready SHALL equal (state == IDLE) and SHALL be deasserted while clr is high.
REQ-020 When cfg_valid and cfg_ready are both high, the block SHALL latch in_sel, out_sel, addr_len and data_len, and clear both counters.
- Next state: ADDR if addr_len != 0; else DATA if data_len != 0; else DONE.
REQ-021 data_in_sel and data_out_sel SHALL equal the latched values in ADDR, DATA and DONE, and SHALL be 0 in IDLE.
REQ-022 addr_en SHALL be 1 only in ADDR; data_en SHALL be 1 only in DATA.
REQ-023 An address beat SHALL be a cycle with mon_addr_valid & mon_addr_ready while in ADDR; each beat SHALL increment addr_cnt by 1.
REQ-024 On the address beat where addr_cnt == addr_len-1, the FSM SHALL go to DATA if data_len != 0, else to DONE.
REQ-025 A data beat SHALL be a cycle with mon_data_valid & mon_data_ready while in DATA; each beat SHALL increment data_cnt by 1.
REQ-026 On the data beat where data_cnt == data_len-1, the FSM SHALL go to DONE.
REQ-027 Handshakes outside their own phase SHALL be ignored and SHALL NOT be counted, including a data beat in the same cycle as the final address beat.
REQ-028 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE.
- The earliest next descriptor SHALL be accepted in the following cycle.
REQ-029 The counters SHALL hold their final values through DONE and IDLE until the next descriptor is accepted; they SHALL never wrap within a transfer.
REQ-030 clr SHALL force IDLE on the next edge from any state, SHALL zero the counters, and SHALL suppress done; clr has priority over every other transition.
REQ-031 Descriptor-to-first-enable latency SHALL be 1 cycle; last-beat-to-done latency SHALL be 1 cycle.

Reset
REQ-032 While rst_n is low, the outputs SHALL be: state = IDLE, cfg_ready = 1, data_in_sel = 0, data_out_sel = 0, addr_en = 0, data_en = 0, busy = 0, done = 0, addr_cnt = 0, data_cnt = 0, and all latched configuration = 0.
REQ-033 Reset assertion mid-transfer SHALL take effect immediately, without waiting for a clock edge; the block SHALL recover in IDLE, with no done pulse.

Verification
REQ-034 Descriptor in_sel=0, out_sel=1, addr_len=3, data_len=5, both sources always valid and ready -> the bench SHALL observe:
- addr_en for 3 cycles, then data_en for 5 cycles;
- done one cycle later, with addr_cnt=3 and data_cnt=5;
- data_out_sel=1 throughout.
REQ-035 addr_len=0, data_len=2 -> the bench SHALL observe no addr_en; data_en SHALL assert in the cycle after acceptance, and done SHALL follow 1 cycle after the second data beat.
REQ-036 addr_len=0, data_len=0 -> the bench SHALL observe the state go directly to DONE, with done high in the cycle after acceptance and both counters at 0.
REQ-037 addr_len=4, with ready deasserted on alternating cycles and spurious data handshakes injected during ADDR -> addr_cnt SHALL count only the qualified address beats, and data_cnt SHALL stay 0 until DATA.
REQ-038 clr asserted after 2 of 5 data beats -> the bench SHALL observe IDLE on the next edge, counters at 0, no done, and the next descriptor accepted normally.
REQ-039 rst_n pulsed low mid-DATA -> all outputs SHALL take their reset values asynchronously, and the bench SHALL observe no done pulse.
